// File: rtl/spu_window_feeder.sv
// rtl/spu_window_feeder.sv - 3x3 sliding-window feeder for the spatial processing unit core
//
// Accepts a row-major raster, one pixel per beat, and emits one registered
// 3x3 neighbourhood per interior pixel. Two line buffers hold the previous
// two rows; a two-column shift register holds the left and middle window
// columns, and the incoming pixel completes the right column.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input pixel handshake
//   in_data, in_sof      pixel value, start-of-frame marker (pixel (0,0))
//   win_valid/win_ready  output window handshake (one-deep output register)
//   win_data             9 pixels, p0 = top-left in the low bits, row-major
//   win_row, win_col     centre coordinates of the window
//   frame_done           one-cycle pulse after the last window of a frame leaves
//   sof_err              sticky: in_sof seen mid-frame (0 unless enabled)
//
// Optional feature macro: SPU_FEEDER_SOF_CHECK_EN
//   When defined, an in_sof beat accepted mid-frame sets sof_err and restarts
//   the frame at (0,0). When undefined, in_sof is ignored outside IDLE.
module spu_window_feeder #(
  parameter int DATA_W = 8,
  parameter int COLS   = 8,
  parameter int ROWS   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sof,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic [7:0]          win_row,
  output logic [7:0]          win_col,
  output logic                frame_done,
  output logic                sof_err
);

  if (COLS < 3 || COLS > 256 || ROWS < 3 || ROWS > 256) begin : g_bad_geometry
    $error("spu_window_feeder: COLS and ROWS must lie in 3..256");
  end

  localparam int         CW       = $clog2(COLS);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [7:0]           row, col;
  logic                 accept, start, store, emit, last_px, drain_ok;
  logic                 frame_done_nxt;
  logic [CW-1:0]        wr_idx;
  logic [DATA_W-1:0]    lb0 [COLS];   // row r-1
  logic [DATA_W-1:0]    lb1 [COLS];   // row r-2
  // Column vectors are packed {bottom, middle, top}, top in the low bits.
  logic [3*DATA_W-1:0]  sr_l, sr_m, new_col;
  logic [9*DATA_W-1:0]  win_nxt;

  // The output register may be refilled in the same cycle it drains.
  assign drain_ok = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;

`ifdef SPU_FEEDER_SOF_CHECK_EN
  assign start = accept && in_sof && (state == IDLE || state == RUN);
`else
  assign start = accept && in_sof && (state == IDLE);
`endif

  // Beats accepted in IDLE without in_sof are dropped here.
  assign store   = accept && (start || state == RUN);
  assign wr_idx  = start ? '0 : col[CW-1:0];
  assign last_px = store && !start && row == LAST_ROW && col == LAST_COL;
  assign emit    = store && !start && row >= 8'd2 && col >= 8'd2;

  assign new_col = {in_data, lb0[wr_idx], lb1[wr_idx]};
  assign win_nxt = {new_col[2*DATA_W +: DATA_W], sr_m[2*DATA_W +: DATA_W], sr_l[2*DATA_W +: DATA_W],
                    new_col[DATA_W   +: DATA_W], sr_m[DATA_W   +: DATA_W], sr_l[DATA_W   +: DATA_W],
                    new_col[0        +: DATA_W], sr_m[0        +: DATA_W], sr_l[0        +: DATA_W]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_px)  state_nxt = DONE;
      DONE:    if (drain_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready       = (state != DONE) && drain_ok;
    frame_done_nxt = (state == DONE) && drain_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= frame_done_nxt;
  end

  // Raster position of the next beat to be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 8'd0;
      col <= 8'd0;
    end else if (store) begin
      if (start) begin
        row <= 8'd0;
        col <= 8'd1;
      end else if (col == LAST_COL) begin
        col <= 8'd0;
        row <= (row == LAST_ROW) ? 8'd0 : row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  // Line buffers and column shift register carry no reset; rows 0/1 and
  // columns 0/1 are always rewritten before they feed an emitted window.
  always_ff @(posedge clk) begin
    if (store) begin
      lb1[wr_idx] <= lb0[wr_idx];
      lb0[wr_idx] <= in_data;
      sr_l        <= sr_m;
      sr_m        <= new_col;
    end
  end

  // Output register; contents hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= 8'd0;
      win_col   <= 8'd0;
    end else if (emit) begin
      win_valid <= 1'b1;
      win_data  <= win_nxt;
      win_row   <= row - 8'd1;
      win_col   <= col - 8'd1;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

`ifdef SPU_FEEDER_SOF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               sof_err <= 1'b0;
    else if (accept && in_sof && state == RUN) sof_err <= 1'b1;
  end
`else
  assign sof_err = 1'b0;
`endif

endmodule

// File: tb/tb_spu_window_feeder.sv
// tb/tb_spu_window_feeder.sv - scoreboard bench for spu_window_feeder (4x4 and 5x3 instances)
module tb_spu_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_sof, win_ready, sel;
  logic [7:0] in_data;

  logic        a_in_ready, a_win_valid, a_frame_done, a_sof_err;
  logic [71:0] a_win_data;
  logic [7:0]  a_win_row, a_win_col;
  logic        b_in_ready, b_win_valid, b_frame_done, b_sof_err;
  logic [71:0] b_win_data;
  logic [7:0]  b_win_row, b_win_col;

  logic        o_in_ready, o_win_valid, o_frame_done, o_sof_err;
  logic [71:0] o_win_data;
  logic [7:0]  o_win_row, o_win_col;

  assign o_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign o_win_valid  = sel ? b_win_valid  : a_win_valid;
  assign o_frame_done = sel ? b_frame_done : a_frame_done;
  assign o_sof_err    = sel ? b_sof_err    : a_sof_err;
  assign o_win_data   = sel ? b_win_data   : a_win_data;
  assign o_win_row    = sel ? b_win_row    : a_win_row;
  assign o_win_col    = sel ? b_win_col    : a_win_col;

  spu_window_feeder #(.DATA_W(8), .COLS(4), .ROWS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_sof(in_sof), .win_valid(a_win_valid), .win_ready(win_ready),
    .win_data(a_win_data), .win_row(a_win_row), .win_col(a_win_col),
    .frame_done(a_frame_done), .sof_err(a_sof_err));

  spu_window_feeder #(.DATA_W(8), .COLS(5), .ROWS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_sof(in_sof), .win_valid(b_win_valid), .win_ready(win_ready),
    .win_data(b_win_data), .win_row(b_win_row), .win_col(b_win_col),
    .frame_done(b_frame_done), .sof_err(b_sof_err));

  typedef struct packed {
    logic [71:0] d;
    logic [7:0]  r;
    logic [7:0]  c;
  } win_t;

  win_t        sbq[$];
  int          n_pass = 0, n_total = 0;
  int          n_got = 0, fd_cnt = 0, stall_cnt = 0;
  logic        stall_arm = 1'b0, lat_arm = 1'b0, lat_pending = 1'b0;
  logic [71:0] held, first_win;

  // Reference model of the frame position, independent of the DUT.
  int          m_cols = 4, m_rows = 4, m_r = 0, m_c = 0;
  logic        m_act = 1'b0;
  logic [7:0]  pix [8][8];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_accept(input logic [7:0] d, input logic s);
    win_t w;
    if (!m_act) begin
      if (s) begin
        m_act = 1'b1; pix[0][0] = d; m_r = 0; m_c = 1;
      end
    end
`ifdef SPU_FEEDER_SOF_CHECK_EN
    else if (s) begin
      pix[0][0] = d; m_r = 0; m_c = 1;
    end
`endif
    else begin
      pix[m_r][m_c] = d;
      if (m_r >= 2 && m_c >= 2) begin
        for (int i = 0; i < 9; i++) w.d[i*8 +: 8] = pix[m_r-2+i/3][m_c-2+i%3];
        w.r = 8'(m_r - 1);
        w.c = 8'(m_c - 1);
        sbq.push_back(w);
        if (lat_arm) begin lat_pending = 1'b1; lat_arm = 1'b0; end
      end
      if (m_c == m_cols - 1) begin
        m_c = 0; m_r++;
        if (m_r == m_rows) m_act = 1'b0;
      end else begin
        m_c++;
      end
    end
  endtask

  // One clock cycle: entered and left at posedge+1, samples at negedge.
  task automatic step(output logic acc);
    win_t e;
    logic lat_now;
    if (stall_arm && o_win_valid) begin
      stall_arm = 1'b0; stall_cnt = 5; held = o_win_data;
    end
    win_ready = (stall_cnt == 0);
    lat_now = lat_pending;
    lat_pending = 1'b0;
    @(negedge clk);
    acc = in_valid && o_in_ready;
    if (lat_now) chk("latency_valid", o_win_valid, 1);
    if (stall_cnt > 0) begin
      chk("stall_in_ready", o_in_ready, 0);
      chk("stall_hold", o_win_data, held);
      stall_cnt--;
    end
    if (o_win_valid && win_ready) begin
      n_got++;
      if (sbq.size() == 0) chk("unexpected_window", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("win_data", o_win_data, e.d);
        chk("win_row", o_win_row, e.r);
        chk("win_col", o_win_col, e.c);
        if (n_got == 1) first_win = o_win_data;
      end
    end
    if (acc) model_accept(in_data, in_sof);
    if (o_frame_done) fd_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    logic acc;
    int   n;
    in_valid = 1'b1; in_data = d; in_sof = s; acc = 1'b0; n = 0;
    while (!acc && n < 50) begin step(acc); n++; end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send(8'(i), i == 0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic end_test(input string tag, input int exp_wins);
    idle(12);
    chk({tag, "_count"}, n_got, exp_wins);
    chk({tag, "_frame_done"}, fd_cnt, 1);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    n_got = 0; fd_cnt = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    sbq.delete(); m_act = 1'b0; n_got = 0; fd_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0; win_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_win_valid", o_win_valid, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_sof_err", o_sof_err, 0);
    chk("rst_win_data", o_win_data, 0);
    rst_n = 1'b1;
    idle(2);

    // Test 1: plain 4x4 frame, full throughput
    lat_arm = 1'b1;
    send_frame(16);
    end_test("t1", 4);
    chk("t1_first_win", first_win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});

    // Test 2: output stall for 5 cycles after first window
    stall_arm = 1'b1;
    send_frame(16);
    end_test("t2", 4);

    // Test 3: junk beats before sof are discarded
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send_frame(16);
    end_test("t3", 4);
    chk("t3_first_win", first_win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});

    // Test 4: async reset after pixel 9, then a fresh frame
    for (int i = 0; i < 10; i++) send(8'(i), i == 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_in_ready", o_in_ready, 1);
    chk("t4_rst_win_valid", o_win_valid, 0);
    chk("t4_rst_row", o_win_row, 0);
    sbq.delete(); m_act = 1'b0; n_got = 0; fd_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    send_frame(16);
    end_test("t4", 4);

    // Test 5: second sof at pixel 6
    for (int i = 0; i < 6; i++) send(8'(i), i == 0);
    send_frame(16);
    end_test("t5", 4);
`ifdef SPU_FEEDER_SOF_CHECK_EN
    chk("t5_sof_err", o_sof_err, 1);
`else
    chk("t5_sof_err", o_sof_err, 0);
`endif

    // Test 6: 5x3 raster on the second instance
    pulse_reset();
    sel = 1'b1; m_cols = 5; m_rows = 3;
    idle(2);
    send_frame(15);
    end_test("t6", 3);
    chk("t6_first_centre", first_win[32 +: 8], 8'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
